// File: rtl/hack_boot_loader_pkg.sv
// Shared definitions for the Hack boot loader: loader state encodings and machine word width.
// Used by both the loader FSM and the instruction ROM.
package hack_boot_loader_pkg;

  localparam int HACK_WORD = 16;

  typedef logic [2:0] state_t;

  localparam state_t LEN_HI  = 3'd0;
  localparam state_t LEN_LO  = 3'd1;
  localparam state_t DATA_HI = 3'd2;
  localparam state_t DATA_LO = 3'd3;
  localparam state_t RUN     = 3'd4;
  localparam state_t ERR     = 3'd5;

  // True in the four states that are still consuming image bytes.
  function automatic logic is_loading(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
  endfunction

endpackage

// File: rtl/hack_boot_loader_inst_rom.sv
// Instruction ROM: DEPTH x 16 words, one synchronous write port and one asynchronous read port.
module hack_inst_rom
  import hack_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [HACK_WORD-1:0]  wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [HACK_WORD-1:0]  rdata
);

  logic [HACK_WORD-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset; clearing 32K words is not free, and the
  // loaded_words guard in the top already hides anything stale.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_boot_loader.sv
// Hack CPU instruction-memory front end: loads a length-prefixed byte image into the ROM while
// holding the CPU in reset, then releases the CPU and serves the instruction at pc.
module hack_boot_loader
  import hack_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_start,
  input  logic [15:0] pc,
  output logic [15:0] inst,
  output logic        cpu_reset,
  output logic [15:0] loaded_words,
  output logic        load_err
);

  // One bit wider than the header so DEPTH itself is representable at ADDR_WIDTH = 16.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  state_t                  state;
  logic [7:0]              hi_byte;
  logic [15:0]             n_words;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  logic                    accept;
  logic [16:0]             hdr_len;
  logic                    last_word;
  logic                    rom_we;
  logic [HACK_WORD-1:0]    rom_rdata;
  logic [15:0]             rd_idx;
  logic                    unused_pc;

  assign in_ready  = is_loading(state);
  assign cpu_reset = (state != RUN);
  assign load_err  = (state == ERR);

  assign accept    = in_valid && in_ready;
  assign hdr_len   = {1'b0, hi_byte, in_data};
  assign last_word = (loaded_words + 16'd1) == n_words;

  // A byte arriving together with reset or load_start is discarded, so it must not write.
  assign rom_we = accept && (state == DATA_LO) && !load_start && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN_HI;
      hi_byte      <= 8'h00;
      n_words      <= 16'h0000;
      wr_addr      <= '0;
      loaded_words <= 16'h0000;
    end else if (load_start) begin
      state        <= LEN_HI;
      wr_addr      <= '0;
      loaded_words <= 16'h0000;
    end else if (accept) begin
      case (state)
        LEN_HI: begin
          hi_byte <= in_data;
          state   <= LEN_LO;
        end
        LEN_LO: begin
          n_words <= {hi_byte, in_data};
          if (hdr_len == 17'd0)       state <= RUN;
          else if (hdr_len > DEPTH)   state <= ERR;
          else                        state <= DATA_HI;
        end
        DATA_HI: begin
          hi_byte <= in_data;
          state   <= DATA_LO;
        end
        DATA_LO: begin
          wr_addr      <= wr_addr + ADDR_WIDTH'(1);
          loaded_words <= loaded_words + 16'd1;
          state        <= last_word ? RUN : DATA_HI;
        end
        default: ;
      endcase
    end
  end

  hack_inst_rom #(.ADDR_WIDTH(ADDR_WIDTH)) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (wr_addr),
    .wdata ({hi_byte, in_data}),
    .raddr (pc[ADDR_WIDTH-1:0]),
    .rdata (rom_rdata)
  );

  // pc bits above the ROM address are deliberately ignored.
  assign rd_idx    = 16'(pc[ADDR_WIDTH-1:0]);
  assign unused_pc = ^pc;
  assign inst      = (rd_idx < loaded_words) ? rom_rdata : 16'h0000;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Self-checking bench for hack_boot_loader: directed scenarios plus random images, checked
// against a word-level model of the image (word list + count), not the loader's byte FSM.
module tb_hack_boot_loader;

  localparam int AW    = 15;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_start;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        cpu_reset;
  logic [15:0] loaded_words;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  // Model: the words of the current image and how many have been committed.
  logic [15:0] model_rom [int];
  int          model_n;

  hack_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load_start   (load_start),
    .pc           (pc),
    .inst         (inst),
    .cpu_reset    (cpu_reset),
    .loaded_words (loaded_words),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t build_image(input wq_t words);
    bq_t b;
    b.push_back(8'(words.size() >> 8));
    b.push_back(8'(words.size()));
    foreach (words[i]) begin
      b.push_back(words[i][15:8]);
      b.push_back(words[i][7:0]);
    end
    return b;
  endfunction

  function automatic void set_model(input wq_t words);
    foreach (words[i]) model_rom[i] = words[i];
    model_n = words.size();
  endfunction

  // Gaps are drawn from 1..max_gap before every byte after the first.
  task automatic send_bytes(input bq_t bytes, input int max_gap, input bit expect_run);
    for (int i = 0; i < bytes.size(); i++) begin
      int gap;
      gap = (i == 0 || max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1));
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bytes[i];
      if (expect_run && i == bytes.size() - 1) chk("cpu_reset_before_last", 32'(cpu_reset), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (expect_run) begin
      chk("cpu_reset_after_last", 32'(cpu_reset), 32'd0);
      chk("in_ready_run", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic read_pc(input string tag, input logic [15:0] p);
    int idx;
    logic [15:0] exp;
    pc = p;
    #1;
    idx = int'(p) % DEPTH;
    exp = (idx < model_n) ? model_rom[idx] : 16'h0000;
    chk(tag, 32'(inst), 32'(exp));
  endtask

  task automatic verify_image(input string tag);
    chk({tag, "_loaded"}, 32'(loaded_words), 32'(model_n));
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    for (int p = 0; p <= model_n; p++) read_pc({tag, "_inst"}, 16'(p));
    for (int k = 0; k < 3; k++) read_pc({tag, "_inst_rnd"}, 16'($urandom));
  endtask

  task automatic pulse_load_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_n = 0;
    chk("ls_in_ready", 32'(in_ready), 32'd1);
    chk("ls_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("ls_loaded", 32'(loaded_words), 32'd0);
    chk("ls_err", 32'(load_err), 32'd0);
  endtask

  initial begin
    wq_t w;
    wq_t w2;
    bq_t b;

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; load_start = 1'b0; pc = 16'h0000;
    model_n = 0;

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_loaded", 32'(loaded_words), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    read_pc("rst_inst0", 16'h0000);
    read_pc("rst_inst_rnd", 16'($urandom));
    reset = 1'b0;

    // 2: fixed three-word image, back to back
    w = '{16'h0005, 16'hEC10, 16'hE308};
    set_model(w);
    send_bytes(build_image(w), 0, 1'b1);
    verify_image("img3");

    // 3: same image with idle gaps
    pulse_load_start();
    set_model(w);
    send_bytes(build_image(w), 3, 1'b1);
    verify_image("img3_gaps");

    // 4: empty image
    pulse_load_start();
    b = '{8'h00, 8'h00};
    send_bytes(b, 0, 1'b1);
    verify_image("empty");

    // 5: oversize header, then recovery
    pulse_load_start();
    b = '{8'h80, 8'h01};
    send_bytes(b, 0, 1'b0);
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    pulse_load_start();
    set_model(w);
    send_bytes(build_image(w), 0, 1'b1);
    verify_image("after_err");

    // N == DEPTH header is legal
    pulse_load_start();
    b = '{8'h80, 8'h00};
    send_bytes(b, 0, 1'b0);
    chk("full_hdr_err", 32'(load_err), 32'd0);
    chk("full_hdr_ready", 32'(in_ready), 32'd1);

    // load_start collides with an offered byte: the byte is discarded
    pulse_load_start();
    b = '{8'h00, 8'h05};
    send_bytes(b, 0, 1'b0);
    @(negedge clk);
    load_start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b0;
    model_n = 0;
    w2 = '{16'hABCD};
    set_model(w2);
    send_bytes(build_image(w2), 0, 1'b1);
    verify_image("collide");

    // 6: reset mid-word, stale ROM hidden, reload
    pulse_load_start();
    b = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    send_bytes(b, 0, 1'b0);
    chk("mid_loaded", 32'(loaded_words), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_n = 0;
    chk("mid_rst_loaded", 32'(loaded_words), 32'd0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    read_pc("mid_rst_inst0", 16'h0000);
    w2 = '{16'h1234};
    set_model(w2);
    send_bytes(build_image(w2), 0, 1'b1);
    verify_image("reload");

    // Random images with random gaps
    for (int t = 0; t < 6; t++) begin
      wq_t wr;
      int n;
      pulse_load_start();
      n = int'($urandom_range(10, 1));
      for (int i = 0; i < n; i++) wr.push_back(16'($urandom));
      set_model(wr);
      send_bytes(build_image(wr), 2, 1'b1);
      verify_image("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
